b1_chan_supervisor: RTL and testbench

- Parametrised N-channel control block for the B1 receiver top level; each channel is one ACQ/TRK pair.
- Generates per-channel power-up and command-driven tracking resets.
- Synchronises and edge-detects the PPS and UART-start inputs.
- Latches a coherent snapshot of every channel's NCO/accumulator state on each event and streams it, one channel per beat, over a valid/ready interface to the UART formatter.

---
 rtl/b1_pkg.sv | 25 ++
 rtl/b1_edge_sync.sv | 44 ++++
 rtl/b1_chan_supervisor.sv | 210 +++++++++++++++++++++
 tb/tb_b1_chan_supervisor.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/b1_pkg.sv
`default_nettype none
// ============================================================================
// Module  : b1_pkg
// Purpose : Shared constants and types for the B1 channel supervisor.
//           Default command bytes, data-path widths, the channel-index
//           width used on the snapshot stream, and the snapshot FSM states.
// Rev     : 1.0  initial release
// ============================================================================
package b1_pkg;

    localparam logic [7:0] c_cmd_all     = 8'd49;   // '1' restarts all channels
    localparam logic [7:0] c_cmd_ch_base = 8'd65;   // 'A'+i restarts channel i

    localparam int c_acc_w   = 24;
    localparam int c_nco_w   = 32;
    localparam int c_phs_w   = 12;
    localparam int c_chidx_w = 3;                    // up to 8 channels

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } snap_state_t;

endpackage
`default_nettype wire

// File: rtl/b1_edge_sync.sv
`default_nettype none
// ============================================================================
// Module  : b1_edge_sync
// Purpose : Brings an asynchronous level into the clk domain through a
//           SYNC_STG-flop synchroniser, then emits a registered one-cycle
//           pulse on each synchronised rising edge.
// Ports   : clk      in  clock
//           rst_n    in  asynchronous active-low reset
//           i_async  in  asynchronous level input
//           o_pulse  out one-cycle rising-edge pulse
// Latency : the pulse is high in the cycle after the (SYNC_STG+1)-th clock
//           edge, counting the first edge that samples the input high as 1.
// Rev     : 1.0  initial release
// ============================================================================
module b1_edge_sync #(
    parameter int SYNC_STG = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_pulse
);

    logic [SYNC_STG-1:0] r_sync;
    logic                r_edge;
    logic                r_pulse;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= '0;
            r_edge  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STG-2:0], i_async};
            r_edge  <= r_sync[SYNC_STG-1];
            // Registered so the pulse drives downstream logic glitch-free.
            r_pulse <= r_sync[SYNC_STG-1] & ~r_edge;
        end
    end

    assign o_pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/b1_chan_supervisor.sv
`default_nettype none
// ============================================================================
// Module  : b1_chan_supervisor
// Purpose : Per-channel ACQ/TRK reset generation, PPS / UART-start event
//           synchronisation, and event-triggered coherent snapshot of all
//           channels streamed one channel per valid/ready beat.
// Ports   : rx_clk, rx_rst_n         clock, async active-low reset
//           rx_pps, rx_uart_start    asynchronous event inputs
//           rx_cmd_vld, rx_cmd_byte  command strobe and byte
//           rx_acc_*, rx_*_nco,
//           rx_prn_phs               per-channel tracking state (packed)
//           tx_ch_rst                active-high reset per channel
//           tx_pps_pulse             one-cycle PPS edge pulse
//           tx_snap_* / rx_snap_rdy  snapshot stream, one channel per beat
//           tx_snap_ovf              sticky: event dropped while streaming
// Rev     : 1.0  initial release
// ============================================================================
module b1_chan_supervisor
    import b1_pkg::*;
#(
    parameter int         NCH         = 2,
    parameter int         RST_CYC     = 100,
    parameter int         SYNC_STG    = 3,
    parameter logic [7:0] CMD_ALL     = c_cmd_all,
    parameter logic [7:0] CMD_CH_BASE = c_cmd_ch_base,
    parameter int         ACC_W       = c_acc_w,
    parameter int         NCO_W       = c_nco_w,
    parameter int         PHS_W       = c_phs_w
) (
    input  logic                   rx_clk,
    input  logic                   rx_rst_n,
    input  logic                   rx_pps,
    input  logic                   rx_uart_start,
    input  logic                   rx_cmd_vld,
    input  logic [7:0]             rx_cmd_byte,
    input  logic [NCH*ACC_W-1:0]   rx_acc_real,
    input  logic [NCH*ACC_W-1:0]   rx_acc_imag,
    input  logic [NCH*NCO_W-1:0]   rx_car_nco,
    input  logic [NCH*NCO_W-1:0]   rx_prn_nco,
    input  logic [NCH*PHS_W-1:0]   rx_prn_phs,
    output logic [NCH-1:0]         tx_ch_rst,
    output logic                   tx_pps_pulse,
    output logic                   tx_snap_vld,
    input  logic                   rx_snap_rdy,
    output logic [c_chidx_w-1:0]   tx_snap_ch,
    output logic                   tx_snap_src,
    output logic                   tx_snap_inrst,
    output logic [ACC_W-1:0]       tx_snap_real,
    output logic [ACC_W-1:0]       tx_snap_imag,
    output logic [NCO_W-1:0]       tx_snap_car,
    output logic [NCO_W-1:0]       tx_snap_prn,
    output logic [PHS_W-1:0]       tx_snap_phs,
    output logic                   tx_snap_ovf
);

    localparam int                   c_cnt_w    = $clog2(RST_CYC + 1);
    localparam logic [c_cnt_w-1:0]   c_rst_load = c_cnt_w'(RST_CYC);
    localparam logic [c_chidx_w-1:0] c_last_idx = c_chidx_w'(NCH - 1);

    // ---------------------------------------------------------------- commands
    logic       w_cmd_all;
    logic [7:0] w_cmd_off;
    logic       w_cmd_in_rng;

    assign w_cmd_all    = rx_cmd_vld && (rx_cmd_byte == CMD_ALL);
    assign w_cmd_off    = rx_cmd_byte - CMD_CH_BASE;
    // Guards against the subtraction wrapping for bytes below the base.
    assign w_cmd_in_rng = rx_cmd_vld && (rx_cmd_byte >= CMD_CH_BASE);

    // ---------------------------------------------------------- channel resets
    for (genvar i = 0; i < NCH; i++) begin : g_chan
        logic               w_hit;
        logic [c_cnt_w-1:0] r_cnt;

        assign w_hit = w_cmd_in_rng && (w_cmd_off == 8'(i));

        // A reload while already counting simply extends the reset.
        always_ff @(posedge rx_clk or negedge rx_rst_n) begin
            if (!rx_rst_n) begin
                r_cnt <= c_rst_load;
            end else if (w_cmd_all || w_hit) begin
                r_cnt <= c_rst_load;
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end

        assign tx_ch_rst[i] = (r_cnt != '0);
    end

    // ------------------------------------------------------------ event inputs
    logic w_pps_pulse;
    logic w_start_pulse;
    logic w_event;

    b1_edge_sync #(.SYNC_STG(SYNC_STG)) u_pps_sync (
        .clk     (rx_clk),
        .rst_n   (rx_rst_n),
        .i_async (rx_pps),
        .o_pulse (w_pps_pulse)
    );

    b1_edge_sync #(.SYNC_STG(SYNC_STG)) u_start_sync (
        .clk     (rx_clk),
        .rst_n   (rx_rst_n),
        .i_async (rx_uart_start),
        .o_pulse (w_start_pulse)
    );

    assign tx_pps_pulse = w_pps_pulse;
    assign w_event      = w_pps_pulse | w_start_pulse;

    // ------------------------------------------------------------ snapshot FSM
    snap_state_t          r_state;
    logic [c_chidx_w-1:0] r_idx;
    logic                 r_vld;
    logic                 r_src;
    logic                 r_ovf;
    logic [NCH-1:0]       r_sh_inrst;
    logic [NCH*ACC_W-1:0] r_sh_real;
    logic [NCH*ACC_W-1:0] r_sh_imag;
    logic [NCH*NCO_W-1:0] r_sh_car;
    logic [NCH*NCO_W-1:0] r_sh_prn;
    logic [NCH*PHS_W-1:0] r_sh_phs;

    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_vld      <= 1'b0;
            r_src      <= 1'b0;
            r_ovf      <= 1'b0;
            r_sh_inrst <= '0;
            r_sh_real  <= '0;
            r_sh_imag  <= '0;
            r_sh_car   <= '0;
            r_sh_prn   <= '0;
            r_sh_phs   <= '0;
        end else begin
            if (w_cmd_all) begin
                r_ovf <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_event) begin
                        // Every channel from the same edge: coherent snapshot.
                        r_sh_inrst <= tx_ch_rst;
                        r_sh_real  <= rx_acc_real;
                        r_sh_imag  <= rx_acc_imag;
                        r_sh_car   <= rx_car_nco;
                        r_sh_prn   <= rx_prn_nco;
                        r_sh_phs   <= rx_prn_phs;
                        r_src      <= ~w_pps_pulse;   // PPS wins a tie
                        r_idx      <= '0;
                        r_vld      <= 1'b1;
                        r_state    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    // Events during a stream are dropped; a set here wins
                    // over a same-cycle clear so the loss is never hidden.
                    if (w_event) begin
                        r_ovf <= 1'b1;
                    end
                    if (rx_snap_rdy) begin
                        if (r_idx == c_last_idx) begin
                            r_idx   <= '0;
                            r_vld   <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    r_vld   <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Beat data is a pure mux of the shadow registers, so it stays stable
    // for as long as the consumer stalls.
    always_comb begin
        tx_snap_inrst = 1'b0;
        tx_snap_real  = '0;
        tx_snap_imag  = '0;
        tx_snap_car   = '0;
        tx_snap_prn   = '0;
        tx_snap_phs   = '0;
        for (int i = 0; i < NCH; i++) begin
            if (r_idx == c_chidx_w'(i)) begin
                tx_snap_inrst = r_sh_inrst[i];
                tx_snap_real  = r_sh_real[i*ACC_W +: ACC_W];
                tx_snap_imag  = r_sh_imag[i*ACC_W +: ACC_W];
                tx_snap_car   = r_sh_car[i*NCO_W +: NCO_W];
                tx_snap_prn   = r_sh_prn[i*NCO_W +: NCO_W];
                tx_snap_phs   = r_sh_phs[i*PHS_W +: PHS_W];
            end
        end
    end

    assign tx_snap_vld = r_vld;
    assign tx_snap_ch  = r_idx;
    assign tx_snap_src = r_src;
    assign tx_snap_ovf = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_b1_chan_supervisor.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_b1_chan_supervisor
// Purpose : Self-checking bench for b1_chan_supervisor (NCH=2, RST_CYC=100,
//           SYNC_STG=3). A behavioural model predicts every output each
//           cycle; directed steps add hand-computed literal expectations.
// Rev     : 1.0  initial release
// ============================================================================
module tb_b1_chan_supervisor;

    localparam int         NCH      = 2;
    localparam int         RST_CYC  = 100;
    localparam int         SYNC_STG = 3;
    localparam int         ACC_W    = 24;
    localparam int         NCO_W    = 32;
    localparam int         PHS_W    = 12;
    localparam logic [7:0] CMD_ALL  = 8'd49;
    localparam logic [7:0] CMD_BASE = 8'd65;

    logic                 rx_clk        = 1'b0;
    logic                 rx_rst_n      = 1'b0;
    logic                 rx_pps        = 1'b0;
    logic                 rx_uart_start = 1'b0;
    logic                 rx_cmd_vld    = 1'b0;
    logic [7:0]           rx_cmd_byte   = 8'd0;
    logic [NCH*ACC_W-1:0] rx_acc_real   = '0;
    logic [NCH*ACC_W-1:0] rx_acc_imag   = '0;
    logic [NCH*NCO_W-1:0] rx_car_nco    = '0;
    logic [NCH*NCO_W-1:0] rx_prn_nco    = '0;
    logic [NCH*PHS_W-1:0] rx_prn_phs    = '0;
    logic                 rx_snap_rdy   = 1'b1;

    logic [NCH-1:0]       tx_ch_rst;
    logic                 tx_pps_pulse;
    logic                 tx_snap_vld;
    logic [2:0]           tx_snap_ch;
    logic                 tx_snap_src;
    logic                 tx_snap_inrst;
    logic [ACC_W-1:0]     tx_snap_real;
    logic [ACC_W-1:0]     tx_snap_imag;
    logic [NCO_W-1:0]     tx_snap_car;
    logic [NCO_W-1:0]     tx_snap_prn;
    logic [PHS_W-1:0]     tx_snap_phs;
    logic                 tx_snap_ovf;

    always #5 rx_clk = ~rx_clk;

    b1_chan_supervisor #(
        .NCH(NCH), .RST_CYC(RST_CYC), .SYNC_STG(SYNC_STG),
        .CMD_ALL(CMD_ALL), .CMD_CH_BASE(CMD_BASE),
        .ACC_W(ACC_W), .NCO_W(NCO_W), .PHS_W(PHS_W)
    ) dut (
        .rx_clk        (rx_clk),
        .rx_rst_n      (rx_rst_n),
        .rx_pps        (rx_pps),
        .rx_uart_start (rx_uart_start),
        .rx_cmd_vld    (rx_cmd_vld),
        .rx_cmd_byte   (rx_cmd_byte),
        .rx_acc_real   (rx_acc_real),
        .rx_acc_imag   (rx_acc_imag),
        .rx_car_nco    (rx_car_nco),
        .rx_prn_nco    (rx_prn_nco),
        .rx_prn_phs    (rx_prn_phs),
        .tx_ch_rst     (tx_ch_rst),
        .tx_pps_pulse  (tx_pps_pulse),
        .tx_snap_vld   (tx_snap_vld),
        .rx_snap_rdy   (rx_snap_rdy),
        .tx_snap_ch    (tx_snap_ch),
        .tx_snap_src   (tx_snap_src),
        .tx_snap_inrst (tx_snap_inrst),
        .tx_snap_real  (tx_snap_real),
        .tx_snap_imag  (tx_snap_imag),
        .tx_snap_car   (tx_snap_car),
        .tx_snap_prn   (tx_snap_prn),
        .tx_snap_phs   (tx_snap_phs),
        .tx_snap_ovf   (tx_snap_ovf)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------ model
    // Reset: each channel is held until an absolute edge number. Events: a
    // rising input produces a pulse SYNC_STG edges after the edge that first
    // sees it high. Snapshot: a queue of pending beats; non-empty == valid.
    typedef struct {
        logic [2:0]       ch;
        logic             src;
        logic             inrst;
        logic [ACC_W-1:0] re;
        logic [ACC_W-1:0] im;
        logic [NCO_W-1:0] car;
        logic [NCO_W-1:0] prn;
        logic [PHS_W-1:0] phs;
    } beat_t;

    beat_t m_q[$];
    int    m_pps_at[$];
    int    m_st_at[$];
    int    m_cyc;
    int    m_until[NCH];
    bit    m_ovf, m_pps_exp, m_st_exp, m_pps_prev, m_st_prev;

    always begin : p_model
        bit             rst_before[NCH];
        bit             ev;
        bit             busy;
        beat_t          b;
        logic [NCH-1:0] exp_rst;
        @(posedge rx_clk);
        if (!rx_rst_n) begin
            m_cyc = 0;
            for (int i = 0; i < NCH; i++) m_until[i] = RST_CYC;
            m_q.delete();
            m_pps_at.delete();
            m_st_at.delete();
            m_ovf = 0; m_pps_exp = 0; m_st_exp = 0; m_pps_prev = 0; m_st_prev = 0;
        end else begin
            m_cyc++;
            for (int i = 0; i < NCH; i++) rst_before[i] = (m_cyc - 1) < m_until[i];
            if (rx_cmd_vld) begin
                if (rx_cmd_byte == CMD_ALL) begin
                    for (int i = 0; i < NCH; i++) m_until[i] = m_cyc + RST_CYC;
                    m_ovf = 0;
                end
                for (int i = 0; i < NCH; i++)
                    if (rx_cmd_byte == 8'(CMD_BASE + i)) m_until[i] = m_cyc + RST_CYC;
            end
            ev   = m_pps_exp || m_st_exp;
            busy = (m_q.size() != 0);
            if (ev && busy) m_ovf = 1;
            if (busy && rx_snap_rdy) void'(m_q.pop_front());
            if (ev && !busy) begin
                for (int i = 0; i < NCH; i++) begin
                    b.ch    = 3'(i);
                    b.src   = !m_pps_exp;
                    b.inrst = rst_before[i];
                    b.re    = rx_acc_real[i*ACC_W +: ACC_W];
                    b.im    = rx_acc_imag[i*ACC_W +: ACC_W];
                    b.car   = rx_car_nco[i*NCO_W +: NCO_W];
                    b.prn   = rx_prn_nco[i*NCO_W +: NCO_W];
                    b.phs   = rx_prn_phs[i*PHS_W +: PHS_W];
                    m_q.push_back(b);
                end
            end
            if (rx_pps && !m_pps_prev) m_pps_at.push_back(m_cyc + SYNC_STG);
            if (rx_uart_start && !m_st_prev) m_st_at.push_back(m_cyc + SYNC_STG);
            m_pps_prev = rx_pps;
            m_st_prev  = rx_uart_start;
            m_pps_exp  = (m_pps_at.size() != 0) && (m_pps_at[0] == m_cyc);
            m_st_exp   = (m_st_at.size() != 0) && (m_st_at[0] == m_cyc);
            if (m_pps_exp) void'(m_pps_at.pop_front());
            if (m_st_exp)  void'(m_st_at.pop_front());
        end
        #1;
        if (rx_rst_n) begin
            for (int i = 0; i < NCH; i++) exp_rst[i] = m_cyc < m_until[i];
            check("m.ch_rst", 64'(tx_ch_rst), 64'(exp_rst));
            check("m.pps_pulse", 64'(tx_pps_pulse), 64'(m_pps_exp));
            check("m.snap_vld", 64'(tx_snap_vld), 64'(m_q.size() != 0));
            check("m.snap_ovf", 64'(tx_snap_ovf), 64'(m_ovf));
            if (m_q.size() != 0 && tx_snap_vld) begin
                check("m.snap_ch", 64'(tx_snap_ch), 64'(m_q[0].ch));
                check("m.snap_src", 64'(tx_snap_src), 64'(m_q[0].src));
                check("m.snap_inrst", 64'(tx_snap_inrst), 64'(m_q[0].inrst));
                check("m.snap_real", 64'(tx_snap_real), 64'(m_q[0].re));
                check("m.snap_imag", 64'(tx_snap_imag), 64'(m_q[0].im));
                check("m.snap_car", 64'(tx_snap_car), 64'(m_q[0].car));
                check("m.snap_prn", 64'(tx_snap_prn), 64'(m_q[0].prn));
                check("m.snap_phs", 64'(tx_snap_phs), 64'(m_q[0].phs));
            end
        end
    end

    // ---------------------------------------------------------------- helpers
    task automatic tick(input int n);
        repeat (n) @(negedge rx_clk);
    endtask

    task automatic send_cmd(input logic [7:0] b);
        @(negedge rx_clk);
        rx_cmd_vld  = 1'b1;
        rx_cmd_byte = b;
        @(negedge rx_clk);
        rx_cmd_vld  = 1'b0;
        rx_cmd_byte = 8'd0;
    endtask

    task automatic set_ch(input int i, input logic [ACC_W-1:0] re, input logic [ACC_W-1:0] im,
                          input logic [NCO_W-1:0] car, input logic [NCO_W-1:0] prn,
                          input logic [PHS_W-1:0] phs);
        rx_acc_real[i*ACC_W +: ACC_W] = re;
        rx_acc_imag[i*ACC_W +: ACC_W] = im;
        rx_car_nco[i*NCO_W +: NCO_W]  = car;
        rx_prn_nco[i*NCO_W +: NCO_W]  = prn;
        rx_prn_phs[i*PHS_W +: PHS_W]  = phs;
    endtask

    task automatic wait_vld(input string name);
        int k = 0;
        while (!tx_snap_vld && k < 40) begin
            @(negedge rx_clk);
            k++;
        end
        check(name, 64'(tx_snap_vld), 64'd1);
    endtask

    task automatic count_beats(input int n, output int beats);
        beats = 0;
        for (int k = 0; k < n; k++) begin
            if (tx_snap_vld && rx_snap_rdy) beats++;
            @(negedge rx_clk);
        end
    endtask

    // --------------------------------------------------------------- stimulus
    initial begin : p_stim
        int beats;
        tick(3);
        check("rst ch_rst", 64'(tx_ch_rst), 64'h3);
        check("rst pps_pulse", 64'(tx_pps_pulse), 64'd0);
        check("rst vld", 64'(tx_snap_vld), 64'd0);
        check("rst ovf", 64'(tx_snap_ovf), 64'd0);
        check("rst ch", 64'(tx_snap_ch), 64'd0);
        check("rst src", 64'(tx_snap_src), 64'd0);
        check("rst car", 64'(tx_snap_car), 64'd0);
        rx_rst_n = 1'b1;

        // Power-up reset: high through edge 99, low from edge 100.
        repeat (99) @(posedge rx_clk);
        #1 check("pwrup ch_rst edge99", 64'(tx_ch_rst), 64'h3);
        @(posedge rx_clk);
        #1 check("pwrup ch_rst edge100", 64'(tx_ch_rst), 64'h0);

        // Per-channel command, extension, out-of-range ignored.
        tick(5);
        send_cmd(8'd66);
        check("cmd B ch_rst", 64'(tx_ch_rst), 64'h2);
        tick(49);
        send_cmd(8'd66);
        tick(99);
        check("extend ch_rst high", 64'(tx_ch_rst), 64'h2);
        tick(1);
        check("extend ch_rst low", 64'(tx_ch_rst), 64'h0);
        send_cmd(8'd67);
        check("cmd C ignored", 64'(tx_ch_rst), 64'h0);

        // PPS snapshot with rdy high.
        set_ch(0, 24'h00A001, 24'h00B001, 32'h1234_5678, 32'h0101_0101, 12'h111);
        set_ch(1, 24'hFFF002, 24'h800002, 32'hCAFE_0001, 32'h0202_0202, 12'hABC);
        rx_pps = 1'b1;
        repeat (3) @(posedge rx_clk);
        #1 check("pps pulse early", 64'(tx_pps_pulse), 64'd0);
        @(posedge rx_clk);
        #1 check("pps pulse on time", 64'(tx_pps_pulse), 64'd1);
        @(posedge rx_clk);
        #1;
        check("pps pulse one cycle", 64'(tx_pps_pulse), 64'd0);
        check("beat0 vld", 64'(tx_snap_vld), 64'd1);
        check("beat0 ch", 64'(tx_snap_ch), 64'd0);
        check("beat0 car", 64'(tx_snap_car), 64'h1234_5678);
        check("beat0 real", 64'(tx_snap_real), 64'h00A001);
        check("beat0 src", 64'(tx_snap_src), 64'd0);
        check("beat0 inrst", 64'(tx_snap_inrst), 64'd0);
        @(posedge rx_clk);
        #1;
        check("beat1 ch", 64'(tx_snap_ch), 64'd1);
        check("beat1 car", 64'(tx_snap_car), 64'hCAFE_0001);
        check("beat1 phs", 64'(tx_snap_phs), 64'hABC);
        @(posedge rx_clk);
        #1 check("stream end vld", 64'(tx_snap_vld), 64'd0);
        tick(10);
        check("held pps no pulse", 64'(tx_pps_pulse), 64'd0);
        check("held pps no vld", 64'(tx_snap_vld), 64'd0);
        rx_pps = 1'b0;
        tick(10);

        // Back-pressure: outputs frozen while inputs move.
        rx_snap_rdy = 1'b0;
        rx_pps      = 1'b1;
        wait_vld("bp vld timeout");
        for (int k = 0; k < 20; k++) begin
            set_ch(0, 24'(k), 24'(k + 1), 32'hDEAD_0000 + 32'(k), 32'h0, 12'(k));
            tick(1);
        end
        check("bp hold ch", 64'(tx_snap_ch), 64'd0);
        check("bp hold car", 64'(tx_snap_car), 64'h1234_5678);
        rx_snap_rdy = 1'b1;
        tick(1);
        check("bp ch after rdy", 64'(tx_snap_ch), 64'd1);
        check("bp car after rdy", 64'(tx_snap_car), 64'hCAFE_0001);
        tick(1);
        check("bp stream end", 64'(tx_snap_vld), 64'd0);
        rx_pps = 1'b0;
        tick(6);

        // Overflow: second PPS during a stream is dropped and flagged.
        rx_snap_rdy = 1'b0;
        rx_pps      = 1'b1;
        wait_vld("ovf vld timeout");
        rx_pps = 1'b0;
        tick(6);
        rx_pps = 1'b1;
        tick(8);
        check("ovf set", 64'(tx_snap_ovf), 64'd1);
        check("ovf stream undisturbed", 64'(tx_snap_ch), 64'd0);
        rx_snap_rdy = 1'b1;
        count_beats(10, beats);
        check("ovf beat count", 64'(beats), 64'(NCH));
        rx_pps = 1'b0;
        send_cmd(CMD_ALL);
        check("cmd all ovf clear", 64'(tx_snap_ovf), 64'd0);
        check("cmd all ch_rst", 64'(tx_ch_rst), 64'h3);

        // Start-only snapshot while channels are in reset.
        rx_uart_start = 1'b1;
        wait_vld("start vld timeout");
        check("start src", 64'(tx_snap_src), 64'd1);
        check("start inrst", 64'(tx_snap_inrst), 64'd1);
        count_beats(6, beats);
        check("start beat count", 64'(beats), 64'(NCH));
        rx_uart_start = 1'b0;
        tick(120);

        // Simultaneous PPS and start: one snapshot, PPS source.
        rx_pps        = 1'b1;
        rx_uart_start = 1'b1;
        wait_vld("both vld timeout");
        check("both src", 64'(tx_snap_src), 64'd0);
        check("both inrst", 64'(tx_snap_inrst), 64'd0);
        count_beats(12, beats);
        check("both beat count", 64'(beats), 64'(NCH));
        check("both no ovf", 64'(tx_snap_ovf), 64'd0);
        rx_pps        = 1'b0;
        rx_uart_start = 1'b0;
        tick(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : p_watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
